ball_move_ctl: RTL
==================

Name: ball_move_ctl

Overview:
- Sequences ball motion on the maze grid.
- Collects the 4-bit direction pulses from the tilt-to-pulse block and arbitrates among pending directions round-robin.
- For each granted move, asks the shared maze map ROM port whether the target cell is a wall, then commits or rejects the move.
- Owns the authoritative ball X/Y position and the goal-reached flag consumed by the display and game logic.

Parameters:
- START_X, 4'd0, ball X loaded at reset/restart
- START_Y, 4'd0, ball Y loaded at reset/restart
- GOAL_X, 4'd15, goal cell X
- GOAL_Y, 4'd15, goal cell Y
- MAP_TIMEOUT, 16, cycles to wait for map_rd_ack before treating the cell as a wall (>=1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- game_restart  in  1  synchronous one-cycle pulse; returns ball to start
- move_pulses  in  4  {x_inc, x_dec, y_inc, y_dec} one-cycle move requests
- map_rd_req  out  1  map read request, held until ack or timeout
- map_addr  out  8  {cand_y, cand_x}, stable while map_rd_req=1
- map_rd_ack  in  1  map data valid; sampled only in REQ
- map_wall  in  1  1 = wall at map_addr; valid with map_rd_ack
- ball_x  out  4  current ball X
- ball_y  out  4  current ball Y
- moved  out  1  one-cycle pulse when the position changes
- blocked  out  1  one-cycle pulse when a move is rejected (wall, edge or timeout)
- goal_reached  out  1  sticky; set when ball_x/ball_y equal GOAL

Behaviour:
- Reset (async, reset=0) and game_restart:
  - ball_x=START_X, ball_y=START_Y; pending=0; rr_ptr=0; state=IDLE.
  - map_rd_req=0, map_addr=0, moved=0, blocked=0, goal_reached=0.
- Pending latches:
  - pending[i] is set by move_pulses[i] and cleared when direction i is granted. A repeat pulse on an already-pending direction coalesces.
  - If x_inc and x_dec are both pending at the start of ARB, both are cleared with no move and no blocked pulse. Same rule for the y pair.
  - Pulses arriving in the same cycle as a grant are captured, except on the granted bit: set wins over clear.
- FSM: IDLE, ARB, REQ, COMMIT.
  - IDLE: if pending!=0, go to ARB.
  - ARB (1 cycle):
    - Apply opposing-pair cancel first. If nothing remains, go to IDLE.
    - Otherwise grant the first pending direction at or after rr_ptr (order 3,2,1,0 for bits x_inc, x_dec, y_inc, y_dec); rr_ptr moves to the next index after the granted one.
    - Compute the candidate cell. If the move would leave the grid (x_inc at 15, x_dec at 0, y_inc at 15, y_dec at 0), go to COMMIT with reject and issue no map read.
    - Otherwise register map_addr, assert map_rd_req, go to REQ.
  - REQ:
    - Hold map_rd_req and map_addr.
    - On map_rd_ack: latch map_wall, drop map_rd_req, go to COMMIT.
    - A timeout counter starts at 0 on entry. When it reaches MAP_TIMEOUT-1 without an ack, treat the cell as a wall, drop the request, go to COMMIT.
  - COMMIT (1 cycle):
    - If not rejected: load the candidate into ball_x/ball_y and pulse moved.
    - Else: pulse blocked.
    - Go to IDLE.
- Outputs:
  - moved and blocked are registered and assert in the cycle after COMMIT.
  - goal_reached is set in the same cycle the new position appears.
- Latency: a pulse at cycle t, with the ack in the first REQ cycle, gives the updated ball_x/ball_y at cycle t+4. Each move is one cell; there is no arithmetic wrap.
- Ordering: at most one map transaction is outstanding. map_rd_ack outside REQ is ignored.
- goal_reached: stays set until reset or game_restart. Moves continue to be processed after the goal.
- game_restart mid-transaction: takes priority over every FSM action. map_rd_req is low the next cycle, and a later ack is ignored.

Test Plan:
- Release reset, ball at (0,0), pulse x_inc, ack with map_wall=0 on the first REQ cycle -> map_addr=8'h01, ball_x=1 at t+4, one moved pulse.
- Ball at (1,0), pulse y_inc, ack with map_wall=1 -> map_addr=8'h11, ball unchanged, one blocked pulse, no moved.
- Ball at (0,0), pulse x_dec -> no map_rd_req ever asserted, blocked pulse, ball stays (0,0).
- Pulse x_inc and x_dec in the same cycle -> no request, no moved, no blocked; pending returns to 0.
- Pulse all four directions in one cycle from (5,5), always ack with no wall -> x pair and y pair cancel, no move; then pulse x_inc and y_dec together -> grants in rr order, final (6,4), two moved pulses.
- Hold map_rd_ack=0 with MAP_TIMEOUT=16 -> map_rd_req high for exactly 16 cycles, then blocked. Separately, assert game_restart during REQ -> req low next cycle, a late ack is ignored, ball at START.
- Walk the ball into (15,15) -> goal_reached=1 with the final moved pulse; stays 1 after a further move; clears on game_restart.

Source files
------------

// File: rtl/ball_move_ctl.sv
// ball_move_ctl
// Sequences ball motion on the 16x16 maze grid. Direction pulses are latched
// into a pending set and arbitrated round-robin. For each granted move the
// target cell is looked up through the shared map ROM port, and the move is
// then committed or rejected. Owns the ball position and the goal flag.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-low reset
//   game_restart  synchronous one-cycle pulse, returns ball to start
//   move_pulses   {x_inc, x_dec, y_inc, y_dec} one-cycle move requests
//   map_rd_req    map read request, held until ack or timeout
//   map_addr      {cand_y, cand_x}, stable while map_rd_req=1
//   map_rd_ack    map data valid (only looked at in REQ)
//   map_wall      1 = wall at map_addr, valid with map_rd_ack
//   ball_x/ball_y current ball position
//   moved         one-cycle pulse when the position changes
//   blocked       one-cycle pulse when a move is rejected
//   goal_reached  sticky goal flag
//
// state  | meaning
// IDLE   | waiting for a pending direction
// ARB    | cancel opposing pairs, grant one direction, edge check
// REQ    | map read outstanding, waiting for ack or timeout
// COMMIT | apply or reject the candidate move

module ball_move_ctl #(
    parameter logic [3:0] START_X     = 4'd0,
    parameter logic [3:0] START_Y     = 4'd0,
    parameter logic [3:0] GOAL_X      = 4'd15,
    parameter logic [3:0] GOAL_Y      = 4'd15,
    parameter int         MAP_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       game_restart,
    input  logic [3:0] move_pulses,
    output logic       map_rd_req,
    output logic [7:0] map_addr,
    input  logic       map_rd_ack,
    input  logic       map_wall,
    output logic [3:0] ball_x,
    output logic [3:0] ball_y,
    output logic       moved,
    output logic       blocked,
    output logic       goal_reached
);

    localparam int TW = (MAP_TIMEOUT > 1) ? $clog2(MAP_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(MAP_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ARB, REQ, COMMIT} state_t;

    state_t        state;
    logic [3:0]    pending;
    logic [1:0]    rr_ptr;
    logic [3:0]    cand_x;
    logic [3:0]    cand_y;
    logic          reject;
    logic [TW-1:0] to_cnt;

    logic [3:0] arb_rem;
    logic       gnt_found;
    logic [1:0] gnt_pos;
    logic [1:0] gnt_bit;
    logic [1:0] scan_pos;
    logic [1:0] scan_bit;
    logic [3:0] nx;
    logic [3:0] ny;
    logic       edge_hit;
    logic [3:0] clr_mask;

    // Round-robin positions 0..3 map to bits 3..0 (x_inc first).
    always_comb begin
        arb_rem = pending;
        if (pending[3] && pending[2]) arb_rem[3:2] = 2'b00;
        if (pending[1] && pending[0]) arb_rem[1:0] = 2'b00;

        gnt_found = 1'b0;
        gnt_pos   = rr_ptr;
        scan_pos  = rr_ptr;
        scan_bit  = 2'd3 - rr_ptr;
        for (int k = 0; k < 4; k++) begin
            scan_pos = rr_ptr + k[1:0];
            scan_bit = 2'd3 - scan_pos;
            if (!gnt_found && arb_rem[scan_bit]) begin
                gnt_found = 1'b1;
                gnt_pos   = scan_pos;
            end
        end
        gnt_bit = 2'd3 - gnt_pos;

        nx       = ball_x;
        ny       = ball_y;
        edge_hit = 1'b0;
        case (gnt_bit)
            2'd3: if (ball_x == 4'hF) edge_hit = 1'b1; else nx = ball_x + 4'd1;
            2'd2: if (ball_x == 4'h0) edge_hit = 1'b1; else nx = ball_x - 4'd1;
            2'd1: if (ball_y == 4'hF) edge_hit = 1'b1; else ny = ball_y + 4'd1;
            default: if (ball_y == 4'h0) edge_hit = 1'b1; else ny = ball_y - 4'd1;
        endcase

        // Cancelled pairs and the granted bit are cleared; new pulses win.
        clr_mask = 4'b0000;
        if (state == ARB) begin
            clr_mask = pending & ~arb_rem;
            if (gnt_found) clr_mask[gnt_bit] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            pending      <= 4'b0000;
            rr_ptr       <= 2'd0;
            cand_x       <= START_X;
            cand_y       <= START_Y;
            reject       <= 1'b0;
            to_cnt       <= '0;
            map_rd_req   <= 1'b0;
            map_addr     <= 8'h00;
            ball_x       <= START_X;
            ball_y       <= START_Y;
            moved        <= 1'b0;
            blocked      <= 1'b0;
            goal_reached <= 1'b0;
        end else if (game_restart) begin
            state        <= IDLE;
            pending      <= 4'b0000;
            rr_ptr       <= 2'd0;
            cand_x       <= START_X;
            cand_y       <= START_Y;
            reject       <= 1'b0;
            to_cnt       <= '0;
            map_rd_req   <= 1'b0;
            map_addr     <= 8'h00;
            ball_x       <= START_X;
            ball_y       <= START_Y;
            moved        <= 1'b0;
            blocked      <= 1'b0;
            goal_reached <= 1'b0;
        end else begin
            moved   <= 1'b0;
            blocked <= 1'b0;
            pending <= (pending & ~clr_mask) | move_pulses;
            case (state)
                IDLE: begin
                    // Looking at incoming pulses too saves a cycle of latency.
                    if ((pending | move_pulses) != 4'b0000) state <= ARB;
                end
                ARB: begin
                    if (!gnt_found) begin
                        state <= IDLE;
                    end else begin
                        rr_ptr <= gnt_pos + 2'd1;
                        cand_x <= nx;
                        cand_y <= ny;
                        if (edge_hit) begin
                            reject <= 1'b1;
                            state  <= COMMIT;
                        end else begin
                            reject     <= 1'b0;
                            map_addr   <= {ny, nx};
                            map_rd_req <= 1'b1;
                            to_cnt     <= '0;
                            state      <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (map_rd_ack) begin
                        reject     <= map_wall;
                        map_rd_req <= 1'b0;
                        state      <= COMMIT;
                    end else if (to_cnt == TO_LAST) begin
                        reject     <= 1'b1;
                        map_rd_req <= 1'b0;
                        state      <= COMMIT;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                COMMIT: begin
                    if (!reject) begin
                        ball_x <= cand_x;
                        ball_y <= cand_y;
                        moved  <= 1'b1;
                        if (cand_x == GOAL_X && cand_y == GOAL_Y) goal_reached <= 1'b1;
                    end else begin
                        blocked <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
